// File: rtl/square_root_iter.sv
// Iterative integer square root: one root bit per clock, valid/ready on both sides.
// Produces floor (or rounded, saturating) root plus the floor remainder.
module square_root_iter #(
   parameter int unsigned DATA_WIDTH = 142,
   parameter int unsigned ROUND      = 0
) (
   input  logic                    clock,
   input  logic                    resetN,
   input  logic [DATA_WIDTH-1:0]   inputData,
   input  logic                    inputValid,
   output logic                    inputReady,
   output logic [DATA_WIDTH/2-1:0] outputRoot,
   output logic [DATA_WIDTH/2:0]   outputRemainder,
   output logic                    outputValid,
   input  logic                    outputReady,
   output logic                    busy
);

   localparam int unsigned ROOT_W = DATA_WIDTH / 2;
   localparam int unsigned REM_W  = ROOT_W + 2;
   localparam int unsigned CNT_W  = $clog2(ROOT_W);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} stateT;

   stateT                 stateQ, stateD;
   logic [DATA_WIDTH-1:0] operandQ, operandD;
   logic [ROOT_W-1:0]     rootQ, rootD;
   logic [REM_W-1:0]      remQ, remD;
   logic [CNT_W-1:0]      cntQ, cntD;
   logic [ROOT_W-1:0]     outRootQ, outRootD;
   logic [ROOT_W:0]       outRemQ, outRemD;
   logic                  outValidQ, outValidD;

   logic                  accept;
   logic [1:0]            pair;
   logic [REM_W-1:0]      remShift, trial, remStep;
   logic [ROOT_W-1:0]     rootStep, rootRounded;
   logic                  takeBit;

   assign inputReady      = (stateQ == StIdle) || ((stateQ == StDone) && outputReady);
   assign accept          = inputValid && inputReady;
   assign busy            = (stateQ == StCalc);
   assign outputRoot      = outRootQ;
   assign outputRemainder = outRemQ;
   assign outputValid     = outValidQ;

   // One restoring step: bring down the next operand bit pair, try subtracting {root,01}.
   always_comb begin
      pair     = operandQ[DATA_WIDTH-1 -: 2];
      remShift = (remQ << 2) | {{ROOT_W{1'b0}}, pair};
      trial    = {rootQ, 2'b01};
      takeBit  = (remShift >= trial);
      remStep  = takeBit ? (remShift - trial) : remShift;
      rootStep = {rootQ[ROOT_W-2:0], takeBit};
   end

   // Round up when the remainder exceeds the floor root; an all-ones root cannot grow.
   always_comb begin
      rootRounded = rootStep;
      if ((ROUND != 0) && (remStep > {2'b00, rootStep}) && !(&rootStep)) begin
         rootRounded = rootStep + ROOT_W'(1);
      end
   end

   always_comb begin
      stateD    = stateQ;
      operandD  = operandQ;
      rootD     = rootQ;
      remD      = remQ;
      cntD      = cntQ;
      outRootD  = outRootQ;
      outRemD   = outRemQ;
      outValidD = outValidQ;

      unique case (stateQ)
         StIdle: begin
            if (accept) begin
               stateD = StCalc;
            end
         end
         StCalc: begin
            operandD = operandQ << 2;
            rootD    = rootStep;
            remD     = remStep;
            cntD     = cntQ - CNT_W'(1);
            if (cntQ == '0) begin
               stateD    = StDone;
               cntD      = '0;
               outRootD  = rootRounded;
               outRemD   = remStep[ROOT_W:0];
               outValidD = 1'b1;
            end
         end
         StDone: begin
            if (outputReady) begin
               outValidD = 1'b0;
               stateD    = accept ? StCalc : StIdle;
            end
         end
         default: begin
            stateD = StIdle;
         end
      endcase

      // Operand load is shared by the IDLE and DONE accept paths.
      if (accept) begin
         operandD = inputData;
         rootD    = '0;
         remD     = '0;
         cntD     = CNT_W'(ROOT_W - 1);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         stateQ    <= StIdle;
         operandQ  <= '0;
         rootQ     <= '0;
         remQ      <= '0;
         cntQ      <= '0;
         outRootQ  <= '0;
         outRemQ   <= '0;
         outValidQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         operandQ  <= operandD;
         rootQ     <= rootD;
         remQ      <= remD;
         cntQ      <= cntD;
         outRootQ  <= outRootD;
         outRemQ   <= outRemD;
         outValidQ <= outValidD;
      end
   end

endmodule
